// File: rtl/pulsador_cond.sv
// pulsador_cond: pedestrian-button front end for the traffic-light controller.
// Synchronises and debounces the raw button, latches a request until the
// controller acknowledges it, then ignores presses for LOCK_TICKS timebase
// ticks. Also generates the 1-cycle timebase tick.
module pulsador_cond #(
  parameter int DIV        = 50_000_000,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int LOCK_TICKS = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic pulsador_in,
  input  logic ack,
  output logic tick,
  output logic estable,
  output logic pulso,
  output logic pedido
);

  // Counter widths: enough bits for each counter's largest value, never below 1.
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int LOCK_W = (LOCK_TICKS > 0) ? $clog2(LOCK_TICKS + 1) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  // With no lockout the LOCK state is unreachable, so the value is irrelevant.
  localparam logic [LOCK_W-1:0] LOCK_LAST = (LOCK_TICKS > 0) ? LOCK_W'(LOCK_TICKS - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    LOCK = 2'd2
  } state_t;

  logic [1:0]        sync_reg;
  logic [DEB_W-1:0]  deb_cnt_reg;
  logic              estable_reg;
  logic              pulso_reg;
  logic [DIV_W-1:0]  div_cnt_reg;
  logic              tick_reg;
  state_t            state_reg;
  state_t            state_next;
  logic [LOCK_W-1:0] lock_cnt_reg;
  logic [LOCK_W-1:0] lock_cnt_next;
  logic              pedido_reg;

  // Two-flop synchroniser for the asynchronous button; only sync_reg[1] is used.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], pulsador_in};
    end
  end

  // Debounce: a new level must persist DEB_CYCLES cycles; any gap restarts the count.
  // The rising-edge pulse is produced on the same edge estable rises.
  always_ff @(posedge clk) begin
    if (!rst) begin
      deb_cnt_reg <= '0;
      estable_reg <= 1'b0;
      pulso_reg   <= 1'b0;
    end else begin
      pulso_reg <= 1'b0;
      if (sync_reg[1] == estable_reg) begin
        deb_cnt_reg <= '0;
      end else if (deb_cnt_reg == DEB_LAST) begin
        estable_reg <= sync_reg[1];
        pulso_reg   <= sync_reg[1];
        deb_cnt_reg <= '0;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
      end
    end
  end

  // Timebase: free-running divider, tick registered one cycle after the terminal count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt_reg <= '0;
      tick_reg    <= 1'b0;
    end else if (div_cnt_reg == DIV_LAST) begin
      div_cnt_reg <= '0;
      tick_reg    <= 1'b1;
    end else begin
      div_cnt_reg <= div_cnt_reg + DIV_W'(1);
      tick_reg    <= 1'b0;
    end
  end

  // Request FSM state, lockout counter and registered pedido.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      lock_cnt_reg <= '0;
      pedido_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lock_cnt_reg <= lock_cnt_next;
      pedido_reg   <= (state_next == PEND);
    end
  end

  // Request FSM next state: ack beats a coincident press; presses are dropped in LOCK.
  always_comb begin
    state_next    = state_reg;
    lock_cnt_next = lock_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pulso_reg) begin
          state_next = PEND;
        end
      end
      PEND: begin
        if (ack) begin
          state_next    = (LOCK_TICKS > 0) ? LOCK : IDLE;
          lock_cnt_next = '0;
        end
      end
      LOCK: begin
        if (tick_reg) begin
          if (lock_cnt_reg == LOCK_LAST) begin
            state_next    = IDLE;
            lock_cnt_next = '0;
          end else begin
            lock_cnt_next = lock_cnt_reg + LOCK_W'(1);
          end
        end
      end
      default: begin
        state_next    = IDLE;
        lock_cnt_next = '0;
      end
    endcase
  end

  assign tick    = tick_reg;
  assign estable = estable_reg;
  assign pulso   = pulso_reg;
  assign pedido  = pedido_reg;

endmodule

// File: tb/tb_pulsador_cond.sv
// tb_pulsador_cond: directed scenarios for pulsador_cond with DIV=4,
// DEB_CYCLES=3, LOCK_TICKS=2. A behavioural model (sample-window debounce,
// modulo timebase, countdown lockout) is checked every cycle, and literal
// expectations pin the key latencies.
module tb_pulsador_cond;

  localparam int DIV   = 4;
  localparam int DEB   = 3;
  localparam int LOCKT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pulsador_in = 1'b0;
  logic ack = 1'b0;
  logic tick;
  logic estable;
  logic pulso;
  logic pedido;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int e = 0;

  always #5 clk = ~clk;

  pulsador_cond #(
    .DIV(DIV),
    .DEB_CYCLES(DEB),
    .LOCK_TICKS(LOCKT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pulsador_in(pulsador_in),
    .ack(ack),
    .tick(tick),
    .estable(estable),
    .pulso(pulso),
    .pedido(pedido)
  );

  task automatic chk(input string name, input logic act, input logic req);
    total_cnt++;
    if (act !== req) begin
      bad_cnt++;
      $display("FAIL %s at t=%0t edge=%0d: got %b want %b", name, $time, e, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic tick_e = 1'b0;
  logic est_e = 1'b0;
  logic pulso_e = 1'b0;
  logic ped_e = 1'b0;
  bit   model_valid = 1'b0;
  bit   pend = 1'b0;
  int   lock_left = 0;
  int   n = 0;
  bit   hist[$];

  task automatic model_step();
    bit   flip;
    logic o_p, o_t, o_e;
    int   s;
    if (rst == 1'b0) begin
      n = 0;
      tick_e = 1'b0;
      est_e = 1'b0;
      pulso_e = 1'b0;
      ped_e = 1'b0;
      pend = 1'b0;
      lock_left = 0;
      hist.delete();
      repeat (DEB + 2) hist.push_back(1'b0);
    end else begin
      n++;
      o_p = pulso_e;
      o_t = tick_e;
      o_e = est_e;
      // request: pending until ack, then LOCKT ticks of deafness
      if (pend) begin
        if (ack) begin
          pend = 1'b0;
          lock_left = LOCKT;
        end
      end else if (lock_left > 0) begin
        if (o_t) lock_left--;
      end else if (o_p) begin
        pend = 1'b1;
      end
      // debounce: level flips when the DEB samples that reached the second
      // synchroniser stage all disagree with the current level
      s = hist.size();
      flip = 1'b1;
      for (int j = s - 1 - DEB; j <= s - 2; j++) begin
        if (hist[j] == o_e) flip = 1'b0;
      end
      if (flip) est_e = ~o_e;
      pulso_e = flip && !o_e;
      tick_e = ((n % DIV) == 0);
      hist.push_back(pulsador_in);
      void'(hist.pop_front());
      ped_e = pend;
    end
    model_valid = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        chk("m_tick", tick, tick_e);
        chk("m_estable", estable, est_e);
        chk("m_pulso", pulso, pulso_e);
        chk("m_pedido", pedido, ped_e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: stimulus did not complete, bad=%0d", bad_cnt);
    $fatal(1, "timeout");
  end

  task automatic tk();
    @(posedge clk);
    #1;
    e++;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // 1: reset with button held, then release
    rst = 1'b0;
    pulsador_in = 1'b1;
    ack = 1'b0;
    repeat (5) tk();
    chk("rst_tick", tick, 1'b0);
    chk("rst_estable", estable, 1'b0);
    chk("rst_pulso", pulso, 1'b0);
    chk("rst_pedido", pedido, 1'b0);
    rst = 1'b1;
    e = 0;
    while (e < 8) begin
      tk();
      chk("t1_estable", estable, e >= 5);
      chk("t1_pulso", pulso, e == 5);
      chk("t1_pedido", pedido, e >= 6);
      chk("t1_tick", tick, (e == 4) || (e == 8));
    end

    // 3: handshake and lockout
    pulsador_in = 1'b0;
    while (e < 14) tk();
    ack = 1'b1;
    tk();
    ack = 1'b0;
    chk("t3_ack_pedido", pedido, 1'b0);
    pulsador_in = 1'b1;
    while (e < 27) begin
      tk();
      if (e == 21) pulsador_in = 1'b0;
      chk("t3_lock_pedido", pedido, 1'b0);
      chk("t3_pulso", pulso, e == 20);
    end
    pulsador_in = 1'b1;
    while (e < 33) begin
      tk();
      chk("t3_pedido", pedido, e >= 33);
    end

    // 4: ack collides with a fresh pulso
    pulsador_in = 1'b0;
    while (e < 39) tk();
    pulsador_in = 1'b1;
    while (e < 44) tk();
    chk("t4_pulso", pulso, 1'b1);
    ack = 1'b1;
    tk();
    ack = 1'b0;
    chk("t4_pedido", pedido, 1'b0);
    while (e < 56) begin
      tk();
      chk("t4_pedido", pedido, 1'b0);
    end

    // 5: stray ack in IDLE and in LOCK
    ack = 1'b1;
    tk();
    ack = 1'b0;
    chk("t5_idle_ack", pedido, 1'b0);
    tk();
    chk("t5_idle_ack", pedido, 1'b0);
    pulsador_in = 1'b0;
    while (e < 64) tk();
    pulsador_in = 1'b1;
    while (e < 69) tk();
    chk("t5_pulso", pulso, 1'b1);
    pulsador_in = 1'b0;
    while (e < 78) begin
      tk();
      case (e)
        71: ack = 1'b1;
        72: begin
          ack = 1'b0;
          pulsador_in = 1'b1;
        end
        73: ack = 1'b1;
        74: ack = 1'b0;
        default: ;
      endcase
      chk("t5_pedido", pedido, (e == 70) || (e == 71) || (e == 78));
      chk("t5_pulso", pulso, e == 77);
    end

    // 6: reset mid-PEND, button still held
    rst = 1'b0;
    repeat (3) tk();
    chk("t6_rst_pedido", pedido, 1'b0);
    chk("t6_rst_tick", tick, 1'b0);
    chk("t6_rst_estable", estable, 1'b0);
    rst = 1'b1;
    e = 0;
    while (e < 6) begin
      tk();
      chk("t6_tick", tick, e == 4);
      chk("t6_estable", estable, e >= 5);
      chk("t6_pedido", pedido, e >= 6);
    end
    // reset mid-LOCK
    ack = 1'b1;
    tk();
    ack = 1'b0;
    chk("t6_lock_pedido", pedido, 1'b0);
    tk();
    rst = 1'b0;
    repeat (2) tk();
    chk("t6_rst2_pedido", pedido, 1'b0);
    rst = 1'b1;
    e = 0;
    while (e < 8) begin
      tk();
      chk("t6b_tick", tick, (e == 4) || (e == 8));
      chk("t6b_pedido", pedido, e >= 6);
    end

    // 2: bounce then hold
    ack = 1'b1;
    tk();
    ack = 1'b0;
    chk("t2_ack_pedido", pedido, 1'b0);
    pulsador_in = 1'b0;
    while (e < 18) tk();
    pulsador_in = 1'b1;
    while (e < 29) begin
      tk();
      case (e)
        19: pulsador_in = 1'b0;
        20: pulsador_in = 1'b1;
        21: pulsador_in = 1'b0;
        22: pulsador_in = 1'b1;
        default: ;
      endcase
      chk("t2_pulso", pulso, e == 27);
      chk("t2_pedido", pedido, e >= 28);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
